// File: rtl/out_channel_checker_if.sv
// out_channel_checker_if
//   Out-channel handshake between the test program (master) and a consumer
//   such as out_channel_checker (slave).
//
//   Handshake: a word moves across the channel on every rising clock edge
//   where out_valid and out_ready are both high. The master holds out_valid
//   and out_data steady until that edge. out_ready may be high or low
//   regardless of out_valid.
//
//   Signals:
//     out_valid  master -> slave  a word is presented
//     out_data   master -> slave  the presented word (W bits)
//     out_ready  slave  -> master consumer can take the word this cycle
interface out_channel_checker_if #(
    parameter int W = 12
);
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/out_channel_checker.sv
// out_channel_checker
//   Consumes the words a test program emits on its out channel, buffers them
//   in a small FIFO and compares them in order against a pre-loaded table of
//   expected values. When the program reports completion the FIFO is
//   drained and finished/success report the verdict.
//
//   Optional feature macro: OUT_CHANNEL_CHECKER_FIRST_FAIL_EN
//     defined   -> first_fail_index / first_fail_data latch the first mismatch
//     undefined -> those outputs are tied to 0, no latch registers exist
//
//   Ports:
//     clock            rising-edge clock
//     reset            asynchronous, active-low reset
//     exp_we           expected-table write strobe (honoured in IDLE only)
//     exp_addr         expected-table index (>= NOut ignored)
//     exp_data         expected value to write
//     exp_count        number of words the program must emit, taken on start
//     start            begin a run (IDLE or DONE)
//     out_ch           out-channel handshake (slave side)
//     check_stall      holds off FIFO pops while high
//     program_done     program reached its end (acted on in RUN only)
//     finished         run complete (state DONE)
//     success          all words matched and count exact; valid with finished
//     mismatches       saturating mismatch count
//     received         saturating count of words compared
//     first_fail_index index of the first mismatching word
//     first_fail_data  word received at the first mismatch
//     dbg_state        current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
module out_channel_checker #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 100,
    parameter int FifoDepth          = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          exp_we,
    input  logic [MemoryElementWidth-1:0] exp_addr,
    input  logic [MemoryElementWidth-1:0] exp_data,
    input  logic [MemoryElementWidth-1:0] exp_count,
    input  logic                          start,
    out_channel_checker_if.slave          out_ch,
    input  logic                          check_stall,
    input  logic                          program_done,
    output logic                          finished,
    output logic                          success,
    output logic [MemoryElementWidth-1:0] mismatches,
    output logic [MemoryElementWidth-1:0] received,
    output logic [MemoryElementWidth-1:0] first_fail_index,
    output logic [MemoryElementWidth-1:0] first_fail_data,
    output logic [1:0]                    dbg_state
);
    localparam int W  = MemoryElementWidth;
    localparam int AW = $clog2(FifoDepth);
    localparam int TW = (NOut > 1) ? $clog2(NOut) : 1;

    localparam logic [W-1:0]  SAT      = '1;
    localparam logic [W-1:0]  CNT_ONE  = W'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
    localparam logic [31:0]   NOUT_U   = 32'(NOut);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    // Expected-value table. Deliberately not reset so a table loaded once
    // survives a reset and can be re-used by the next run.
    logic [W-1:0] exp_table [NOut];

    // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
    logic [W-1:0] fifo_mem [FifoDepth];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    logic [W-1:0] count_q;
    logic [W-1:0] received_q;
    logic [W-1:0] mismatches_q;

    logic         active;
    logic         fifo_empty;
    logic         fifo_full;
    logic         push;
    logic         pop;
    logic         run_start;
    logic [W-1:0] head;
    logic         table_we;
    logic         in_count;
    logic         in_table;
    logic         word_ok;
    logic         mismatch;
    logic [TW-1:0] rd_idx;
    logic [TW-1:0] wr_idx;

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    assign active     = (state == RUN) || (state == DRAIN);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign out_ch.out_ready = active && !fifo_full;
    assign push             = out_ch.out_valid && out_ch.out_ready;
    assign pop              = active && !fifo_empty && !check_stall;
    assign run_start        = start && ((state == IDLE) || (state == DONE));
    assign head             = fifo_mem[rd_ptr[AW-1:0]];

    assign wr_idx   = exp_addr[TW-1:0];
    assign rd_idx   = received_q[TW-1:0];
    assign table_we = (state == IDLE) && exp_we &&
                      ({{(32 - W){1'b0}}, exp_addr} < NOUT_U);

    // A word beyond the latched count is an extra word and always fails.
    // A word whose index lies past the end of the table has no expected
    // entry to compare against, so it fails as well.
    assign in_count = (received_q < count_q);
    assign in_table = ({{(32 - W){1'b0}}, received_q} < NOUT_U);
    assign word_ok  = in_count && in_table && (head == exp_table[rd_idx]);
    assign mismatch = pop && !word_ok;

    // ------------------------------------------------------------------
    // Expected table (no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (table_we) begin
            exp_table[wr_idx] <= exp_data;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= out_ch.out_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (run_start) begin
            // Push cannot coincide with run_start: out_ready is low in
            // IDLE and DONE.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            received_q   <= '0;
            mismatches_q <= '0;
        end else if (run_start) begin
            count_q      <= exp_count;
            received_q   <= '0;
            mismatches_q <= '0;
        end else if (pop) begin
            if (received_q != SAT) begin
                received_q <= received_q + CNT_ONE;
            end
            if (!word_ok && (mismatches_q != SAT)) begin
                mismatches_q <= mismatches_q + CNT_ONE;
            end
        end
    end

    assign received   = received_q;
    assign mismatches = mismatches_q;

    // ------------------------------------------------------------------
    // First-fail latch
    // ------------------------------------------------------------------
`ifdef OUT_CHANNEL_CHECKER_FIRST_FAIL_EN
    logic         ff_seen;
    logic [W-1:0] ff_index;
    logic [W-1:0] ff_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ff_seen  <= 1'b0;
            ff_index <= '0;
            ff_data  <= '0;
        end else if (run_start) begin
            ff_seen  <= 1'b0;
            ff_index <= '0;
            ff_data  <= '0;
        end else if (mismatch && !ff_seen) begin
            ff_seen  <= 1'b1;
            ff_index <= received_q;
            ff_data  <= head;
        end
    end

    assign first_fail_index = ff_index;
    assign first_fail_data  = ff_data;
`else
    assign first_fail_index = '0;
    assign first_fail_data  = '0;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (program_done) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // A word accepted in the same cycle must still be checked,
                // so leave only when nothing is buffered or arriving.
                if (fifo_empty && !push) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign finished  = (state == DONE);
    assign success   = finished && (mismatches_q == '0) && (received_q == count_q);
    assign dbg_state = state;

    // mismatch is only consumed by the first-fail latch.
    logic unused_ok;
    assign unused_ok = mismatch;

endmodule

// File: tb/tb_out_channel_checker.sv
module tb_out_channel_checker;
    localparam int W     = 12;
    localparam int NOUT  = 100;
    localparam int DEPTH = 4;

`ifdef OUT_CHANNEL_CHECKER_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset and DUT
    // ------------------------------------------------------------------
    logic         clock;
    logic         reset;
    logic         exp_we;
    logic [W-1:0] exp_addr;
    logic [W-1:0] exp_data;
    logic [W-1:0] exp_count;
    logic         start;
    logic         check_stall;
    logic         program_done;
    logic         finished;
    logic         success;
    logic [W-1:0] mismatches;
    logic [W-1:0] received;
    logic [W-1:0] first_fail_index;
    logic [W-1:0] first_fail_data;
    logic [1:0]   dbg_state;

    out_channel_checker_if #(.W(W)) out_ch ();

    out_channel_checker #(
        .MemoryElementWidth (W),
        .NOut               (NOUT),
        .FifoDepth          (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .exp_we           (exp_we),
        .exp_addr         (exp_addr),
        .exp_data         (exp_data),
        .exp_count        (exp_count),
        .start            (start),
        .out_ch           (out_ch),
        .check_stall      (check_stall),
        .program_done     (program_done),
        .finished         (finished),
        .success          (success),
        .mismatches       (mismatches),
        .received         (received),
        .first_fail_index (first_fail_index),
        .first_fail_data  (first_fail_data),
        .dbg_state        (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int           n_cmp;
    int           n_err;
    logic [W-1:0] tab_m [NOUT];   // model of the expected table
    logic [W-1:0] exp_q [$];      // words the DUT accepted this run, in order
    int           cnt_m;          // count latched at start
    bit           in_idle;        // table writes are honoured only in IDLE

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (all start and end 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic do_reset();
        reset            = 1'b0;
        exp_we           = 1'b0;
        exp_addr         = '0;
        exp_data         = '0;
        exp_count        = '0;
        start            = 1'b0;
        check_stall      = 1'b0;
        program_done     = 1'b0;
        out_ch.out_valid = 1'b0;
        out_ch.out_data  = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        in_idle = 1'b1;
    endtask

    task automatic load_entry(input int addr, input logic [W-1:0] data);
        exp_we   = 1'b1;
        exp_addr = W'(addr);
        exp_data = data;
        @(posedge clock);
        #1 exp_we = 1'b0;
        if (in_idle && addr < NOUT) tab_m[addr] = data;
    endtask

    task automatic start_run(input int cnt);
        exp_count = W'(cnt);
        start     = 1'b1;
        @(posedge clock);
        #1 start  = 1'b0;
        in_idle = 1'b0;
        cnt_m   = cnt;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [W-1:0] d, input bit with_done, input bit rnd_stall);
        int t;
        bit acc;
        t   = 0;
        acc = 1'b0;
        out_ch.out_valid = 1'b1;
        out_ch.out_data  = d;
        program_done     = with_done;
        while (!acc && t < 200) begin
            if (rnd_stall) check_stall = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            if (out_ch.out_ready === 1'b1) acc = 1'b1;
            @(posedge clock);
            #1;
            t++;
        end
        out_ch.out_valid = 1'b0;
        program_done     = 1'b0;
        if (acc) exp_q.push_back(d);
        chk("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_finished();
        int t;
        t = 0;
        @(negedge clock);
        while (finished !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        chk("finish_seen", 32'(finished), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic finish_run(input bit pulse_done);
        check_stall = 1'b0;
        if (pulse_done) begin
            program_done = 1'b1;
            @(posedge clock);
            #1 program_done = 1'b0;
        end
        wait_finished();
    endtask

    // Verdict from the rules: the k-th accepted word must equal table[k]
    // for k below the latched count; any word beyond that count is wrong.
    task automatic check_results(input string tag);
        int e_recv;
        int e_mis;
        int e_ffi;
        int e_ffd;
        bit seen;
        bit bad;
        bit e_succ;
        e_recv = 0;
        e_mis  = 0;
        e_ffi  = 0;
        e_ffd  = 0;
        seen   = 1'b0;
        foreach (exp_q[i]) begin
            bad = (i >= cnt_m) || (exp_q[i] !== tab_m[i]);
            e_recv++;
            if (bad) begin
                e_mis++;
                if (!seen) begin
                    seen  = 1'b1;
                    e_ffi = i;
                    e_ffd = int'(exp_q[i]);
                end
            end
        end
        e_succ = (e_mis == 0) && (e_recv == cnt_m);
        if (!FF_EN) begin
            e_ffi = 0;
            e_ffd = 0;
        end
        @(negedge clock);
        chk({tag, "_finished"},   32'(finished),         32'd1);
        chk({tag, "_success"},    32'(success),          32'(e_succ));
        chk({tag, "_received"},   32'(received),         32'(e_recv));
        chk({tag, "_mismatches"}, 32'(mismatches),       32'(e_mis));
        chk({tag, "_ff_index"},   32'(first_fail_index), 32'(e_ffi));
        chk({tag, "_ff_data"},    32'(first_fail_data),  32'(e_ffd));
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},      32'(out_ch.out_ready), 32'd0);
        chk({tag, "_finished"},   32'(finished),         32'd0);
        chk({tag, "_success"},    32'(success),          32'd0);
        chk({tag, "_mismatches"}, 32'(mismatches),       32'd0);
        chk({tag, "_received"},   32'(received),         32'd0);
        chk({tag, "_ff_index"},   32'(first_fail_index), 32'd0);
        chk({tag, "_ff_data"},    32'(first_fail_data),  32'd0);
        chk({tag, "_state"},      32'(dbg_state),        32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int m;
        bit done_used;
        logic [W-1:0] d;

        n_cmp = 0;
        n_err = 0;
        cnt_m = 0;

        // Reset values while reset is held.
        do_reset();
        reset = 1'b0;
        #1 check_reset_values("rst");
        @(posedge clock);
        #1 reset = 1'b1;

        // Single correct word.
        load_entry(0, 12'd2);
        start_run(1);
        @(negedge clock);
        chk("ready_after_start", 32'(out_ch.out_ready), 32'd1);
        @(posedge clock);
        #1;
        push_word(12'd2, 1'b0, 1'b0);
        finish_run(1'b1);
        check_results("one_ok");

        // DONE -> RUN directly, wrong word.
        start_run(1);
        push_word(12'd3, 1'b0, 1'b0);
        finish_run(1'b1);
        check_results("one_bad");

        // Too few words; a table write during RUN must be ignored.
        do_reset();
        load_entry(0, 12'd5);
        load_entry(1, 12'd7);
        start_run(2);
        load_entry(0, 12'd99);
        push_word(12'd5, 1'b0, 1'b0);
        finish_run(1'b1);
        check_results("short");

        // Stall fills the FIFO, release drains one word per cycle.
        do_reset();
        for (int i = 0; i < 4; i++) load_entry(i, W'(i + 1));
        start_run(4);
        check_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_word(W'(i + 1), 1'b0, 1'b0);
        @(negedge clock);
        chk("stall_full_ready", 32'(out_ch.out_ready), 32'd0);
        chk("stall_no_pop", 32'(received), 32'd0);
        check_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk($sformatf("drain_recv_%0d", k), 32'(received), 32'(k));
        end
        @(posedge clock);
        #1;
        finish_run(1'b1);
        check_results("stall");

        // Extra word past the count.
        start_run(1);
        push_word(12'd1, 1'b0, 1'b0);
        push_word(12'd9, 1'b0, 1'b0);
        finish_run(1'b1);
        check_results("extra");

        // Asynchronous reset in the middle of a run.
        start_run(4);
        check_stall = 1'b1;
        push_word(12'd1, 1'b0, 1'b0);
        push_word(12'd2, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        check_stall = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        in_idle = 1'b1;
        start_run(4);
        for (int i = 0; i < 4; i++) push_word(W'(i + 1), 1'b0, 1'b0);
        finish_run(1'b1);
        check_results("after_rst");

        // program_done on the same edge as the final push.
        start_run(4);
        for (int i = 0; i < 3; i++) push_word(W'(i + 1), 1'b0, 1'b0);
        push_word(12'd4, 1'b1, 1'b0);
        finish_run(1'b0);
        check_results("done_with_push");

        // Randomised runs.
        for (int r = 0; r < 16; r++) begin
            do_reset();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) load_entry(i, W'($urandom_range(0, 4095)));
            // 128 + i aliases index i if the address range check is lost.
            load_entry(128 + $urandom_range(0, n - 1), W'($urandom_range(0, 4095)));
            start_run(n);
            m = n - 1 + $urandom_range(0, 2);
            done_used = 1'b0;
            for (int j = 0; j < m; j++) begin
                if (j < n && $urandom_range(0, 3) != 0) d = tab_m[j];
                else d = W'($urandom_range(0, 4095));
                if (j == m - 1 && $urandom_range(0, 1) == 1) begin
                    done_used = 1'b1;
                    push_word(d, 1'b1, 1'b1);
                end else begin
                    push_word(d, 1'b0, 1'b1);
                end
            end
            finish_run(!done_used);
            check_results($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
